// File: rtl/ycbcr_to_rgb.sv
// AXI4-Stream YCbCr -> RGB converter: 3-stage fixed-point pipeline with valid/ready backpressure.
// Optional per-frame/per-line statistics enabled by defining YCC2RGB_STATS_EN.
module ycbcr_to_rgb #(
    parameter int Y_OFFSET = 16,
    parameter int C_OFFSET = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Sel,
    input  logic [23:0] Sel_YCbCr,
    input  logic [23:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    output logic        s_axis_video_tready,
    input  logic        s_axis_video_tlast,
    input  logic        s_axis_video_tuser,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tlast,
    output logic        m_axis_video_tuser
`ifdef YCC2RGB_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] line_px_cnt
`endif
);
    localparam int STAGES = 3;

    logic [STAGES:1] vld_pipe, last_pipe, user_pipe;
    logic            ce;
    logic [23:0]     pix;

    logic signed [9:0]  yp;
    logic signed [8:0]  cbp, crp;
    logic signed [18:0] ybase, pr, pgb, pgr, pb;
    logic signed [19:0] sum_r, sum_g, sum_b;

    // Whole pipeline moves as one; only a stalled, occupied output stage blocks it.
    assign ce                  = !vld_pipe[STAGES] || m_axis_video_tready;
    assign s_axis_video_tready = ce;
    assign m_axis_video_tvalid = vld_pipe[STAGES];
    assign m_axis_video_tlast  = last_pipe[STAGES];
    assign m_axis_video_tuser  = user_pipe[STAGES];
    assign pix                 = Sel ? Sel_YCbCr : s_axis_video_tdata;

    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        logic signed [19:0] s;
        s = v >>> 8;
        if (s[19])             return 8'h00;
        else if (s > 20'sd255) return 8'hFF;
        else                   return s[7:0];
    endfunction

    always_comb begin
        sum_r = 20'(ybase) + 20'(pr);
        sum_g = 20'(ybase) - 20'(pgb) - 20'(pgr);
        sum_b = 20'(ybase) + 20'(pb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe           <= '0;
            last_pipe          <= '0;
            user_pipe          <= '0;
            yp                 <= '0;
            cbp                <= '0;
            crp                <= '0;
            ybase              <= '0;
            pr                 <= '0;
            pgb                <= '0;
            pgr                <= '0;
            pb                 <= '0;
            m_axis_video_tdata <= '0;
        end else if (ce) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], s_axis_video_tvalid};
            last_pipe <= {last_pipe[STAGES-1:1], s_axis_video_tlast};
            user_pipe <= {user_pipe[STAGES-1:1], s_axis_video_tuser};
            // Stage 1: remove offsets, widened so Y below offset stays negative
            yp  <= signed'({2'b00, pix[7:0]}) - 10'(Y_OFFSET);
            cbp <= signed'({1'b0, pix[15:8]}) - 9'(C_OFFSET);
            crp <= signed'({1'b0, pix[23:16]}) - 9'(C_OFFSET);
            // Stage 2: coefficients scaled by 256; ybase carries the +0.5 rounding term
            ybase <= {yp[9], yp, 8'h80};
            pr    <= 19'(crp) * 19'sd359;
            pgb   <= 19'(cbp) * 19'sd88;
            pgr   <= 19'(crp) * 19'sd183;
            pb    <= 19'(cbp) * 19'sd454;
            // Stage 3: codebase channel order is {R,B,G}
            m_axis_video_tdata <= {clamp8(sum_r), clamp8(sum_b), clamp8(sum_g)};
        end
    end

`ifdef YCC2RGB_STATS_EN
    logic        xfer;
    logic [15:0] px_cnt, px_next;

    assign xfer    = vld_pipe[STAGES] && m_axis_video_tready;
    assign px_next = (user_pipe[STAGES] ? 16'd0 : px_cnt) + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            line_px_cnt <= '0;
            px_cnt      <= '0;
        end else if (xfer) begin
            if (user_pipe[STAGES]) frame_cnt <= frame_cnt + 16'd1;
            if (last_pipe[STAGES]) begin
                line_px_cnt <= px_next;
                px_cnt      <= '0;
            end else begin
                px_cnt      <= px_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Directed self-checking bench for ycbcr_to_rgb; expected pixels are hand-computed.
module tb_ycbcr_to_rgb;
    logic        clk = 0;
    logic        rst = 1;
    logic        Sel = 0;
    logic [23:0] Sel_YCbCr = '0;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 0, s_tlast = 0, s_tuser = 0;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tuser;
    logic        m_tready = 0;
`ifdef YCC2RGB_STATS_EN
    logic [15:0] frame_cnt, line_px_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ycbcr_to_rgb dut (
        .clk                 (clk),
        .rst                 (rst),
        .Sel                 (Sel),
        .Sel_YCbCr           (Sel_YCbCr),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tuser  (s_tuser),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tuser  (m_tuser)
`ifdef YCC2RGB_STATS_EN
        ,
        .frame_cnt           (frame_cnt),
        .line_px_cnt         (line_px_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic drain();
        s_tvalid = 0; s_tlast = 0; s_tuser = 0; Sel = 0; m_tready = 1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%0b exp=0", m_tvalid); end
        checks++;
        if (m_tdata !== 24'h0) begin errors++; $display("FAIL reset_tdata got=%06h exp=000000", m_tdata); end
        checks++;
        if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
            errors++; $display("FAIL reset_sideband got=%0b%0b exp=00", m_tlast, m_tuser);
        end
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%0b exp=1", s_tready); end
        @(negedge clk); @(negedge clk);
        rst = 0;
    endtask

    // One beat with tready=1: not valid two edges after acceptance, valid with data on the third.
    task automatic test_pixel(input logic [23:0] pix, input logic [23:0] exp, input string nm);
        m_tready = 1;
        @(posedge clk); #1;
        s_tvalid = 1; s_tdata = pix;
        @(posedge clk); #1;
        s_tvalid = 0;
        @(posedge clk); #1;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL %s_early tvalid got=%0b exp=0", nm, m_tvalid); end
        @(posedge clk); #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== exp) begin
            errors++; $display("FAIL %s got vld=%0b data=%06h exp vld=1 data=%06h", nm, m_tvalid, m_tdata, exp);
        end
        drain();
    endtask

    task automatic test_sel();
        m_tready = 1;
        @(posedge clk); #1;
        Sel = 1; Sel_YCbCr = 24'h80FF80; s_tdata = 24'h808010;
        s_tvalid = 1; s_tlast = 1; s_tuser = 1;
        @(posedge clk); #1;
        s_tvalid = 0; s_tlast = 0; s_tuser = 0; Sel = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 24'h70FF44) begin
            errors++; $display("FAIL sel_override got vld=%0b data=%06h exp vld=1 data=70ff44", m_tvalid, m_tdata);
        end
        checks++;
        if (m_tlast !== 1'b1 || m_tuser !== 1'b1) begin
            errors++; $display("FAIL sel_sideband got last=%0b user=%0b exp 1 1", m_tlast, m_tuser);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [23:0] pix [4];
        logic [23:0] exp [4];
        pix = '{24'h808020, 24'h808040, 24'h808060, 24'h808080};
        exp = '{24'h101010, 24'h303030, 24'h505050, 24'h707070};
        m_tready = 1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c >= 3 && c < 7) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== exp[c-3]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d got vld=%0b data=%06h exp vld=1 data=%06h", c-3, m_tvalid, m_tdata, exp[c-3]);
                end
            end
            s_tvalid = (c < 4);
            s_tdata  = (c < 4) ? pix[c] : 24'h0;
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [23:0] pix [8];
        logic [23:0] exp [8];
        logic [23:0] held_d;
        logic        held_l, stalled, acc;
        int src, snk, cyc;
        pix = '{24'h808010, 24'h8080FF, 24'hFF8080, 24'h800010,
                24'h808040, 24'h808060, 24'h8080A0, 24'h808000};
        exp = '{24'h000000, 24'hEFEFEF, 24'hFF7015, 24'h00002C,
                24'h303030, 24'h505050, 24'h909090, 24'h000000};
        src = 0; snk = 0; cyc = 0; stalled = 0; acc = 0; held_d = '0; held_l = 0;
        while (snk < 8 && cyc < 300) begin
            @(posedge clk); #1;
            if (acc) src++;
            s_tvalid = (src < 8);
            s_tdata  = (src < 8) ? pix[src] : 24'h0;
            s_tlast  = (src == 7);
            m_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (s_tready !== (!m_tvalid || m_tready)) begin
                errors++; $display("FAIL bp_tready got=%0b exp=%0b", s_tready, (!m_tvalid || m_tready));
            end
            if (stalled) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tlast !== held_l) begin
                    errors++;
                    $display("FAIL bp_stable got vld=%0b data=%06h last=%0b exp vld=1 data=%06h last=%0b",
                             m_tvalid, m_tdata, m_tlast, held_d, held_l);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (m_tdata !== exp[snk] || m_tlast !== (snk == 7)) begin
                    errors++;
                    $display("FAIL bp_beat%0d got data=%06h last=%0b exp data=%06h last=%0b",
                             snk, m_tdata, m_tlast, exp[snk], (snk == 7));
                end
                snk++;
                stalled = 0;
            end else if (m_tvalid) begin
                stalled = 1; held_d = m_tdata; held_l = m_tlast;
            end else begin
                stalled = 0;
            end
            acc = s_tvalid && s_tready;
            cyc++;
        end
        checks++;
        if (snk != 8 || src != 8) begin
            errors++; $display("FAIL bp_count got out=%0d in=%0d exp 8 8", snk, src);
        end
        drain();
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_extra got tvalid=%0b exp=0", m_tvalid); end
    endtask

    task automatic test_reset_midline();
        m_tready = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            s_tvalid = 1; s_tdata = 24'h808040; s_tlast = (i == 2);
        end
        @(posedge clk); #1;
        s_tvalid = 0; s_tlast = 0;
        checks++;
        if (m_tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_prefill got tvalid=%0b exp=1", m_tvalid); end
        #2 rst = 1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got vld=%0b last=%0b exp 0 0", m_tvalid, m_tlast);
        end
        @(negedge clk);
        rst = 0; m_tready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d got tvalid=%0b exp=0", i, m_tvalid); end
        end
    endtask

`ifdef YCC2RGB_STATS_EN
    task automatic test_stats();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        m_tready = 1;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk); #1;
                    s_tvalid = 1; s_tdata = 24'h808080;
                    s_tuser = (r == 0 && c == 0); s_tlast = (c == 3);
                end
        drain();
        checks++;
        if (frame_cnt !== 16'd2) begin errors++; $display("FAIL stats_frames got=%0d exp=2", frame_cnt); end
        checks++;
        if (line_px_cnt !== 16'd4) begin errors++; $display("FAIL stats_linepx got=%0d exp=4", line_px_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_pixel(24'h808010, 24'h000000, "black");
        test_pixel(24'h8080FF, 24'hEFEFEF, "top");
        test_pixel(24'hFF8080, 24'hFF7015, "pos_clamp");
        test_pixel(24'h800010, 24'h00002C, "neg_clamp");
        test_pixel(24'h808000, 24'h000000, "y_below_offset");
        test_sel();
        test_back_to_back();
        test_backpressure();
        test_reset_midline();
`ifdef YCC2RGB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
